// File: rtl/adder8_bist.sv
// Built-in self test for an external 8-bit adder: LFSR operands, sum checking, error counting.
// Optional first-failure capture is enabled by defining ADDER8_BIST_FAILCAP_EN.
module adder8_bist #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] sum_in,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       fail_valid,
    output logic [7:0] fail_a,
    output logic [7:0] fail_b
);

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        start_accept;
    logic        in_check;
    logic        mismatch;
    logic        last_vec;
    logic [7:0]  exp_sum;
    logic [15:0] vec_cnt_inc;
    logic        lfsr_fb;

    assign start_accept = start && ((state_q == StIdle) || (state_q == StDone));
    assign in_check     = (state_q == StCheck);
    assign exp_sum      = op_a_q + op_b_q;
    assign mismatch     = in_check && (sum_in != exp_sum);
    assign vec_cnt_inc  = vec_cnt_q + 16'd1;
    assign last_vec     = (vec_cnt_inc == 16'(NUM_VECTORS));
    assign lfsr_fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StDrive;
            StDrive:        state_d = StCheck;
            StCheck:        state_d = last_vec ? StDone : StDrive;
            default:        state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == StDrive) || (state_q == StCheck);
        done = (state_q == StDone);
        pass = done && (err_cnt_q == 8'd0);
    end

    // Datapath next-state
    always_comb begin
        lfsr_d    = lfsr_q;
        vec_cnt_d = vec_cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        err_cnt_d = err_cnt_q;
        if (start_accept) begin
            lfsr_d    = SEED;
            vec_cnt_d = 16'd0;
            err_cnt_d = 8'd0;
        end else if (state_q == StDrive) begin
            op_a_d = lfsr_q[15:8];
            op_b_d = lfsr_q[7:0];
        end else if (in_check) begin
            lfsr_d    = {lfsr_q[14:0], lfsr_fb};
            vec_cnt_d = vec_cnt_inc;
            if (mismatch && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q    <= SEED;
            vec_cnt_q <= 16'd0;
            op_a_q    <= 8'd0;
            op_b_q    <= 8'd0;
            err_cnt_q <= 8'd0;
        end else begin
            lfsr_q    <= lfsr_d;
            vec_cnt_q <= vec_cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign err_count = err_cnt_q;

`ifdef ADDER8_BIST_FAILCAP_EN
    logic       fail_valid_q, fail_valid_d;
    logic [7:0] fail_a_q, fail_a_d;
    logic [7:0] fail_b_q, fail_b_d;

    // Only the first mismatch of a run is latched.
    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        if (start_accept) begin
            fail_valid_d = 1'b0;
            fail_a_d     = 8'd0;
            fail_b_d     = 8'd0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_a_d     = op_a_q;
            fail_b_d     = op_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_a_q     <= 8'd0;
            fail_b_q     <= 8'd0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;
`else
    assign fail_valid = 1'b0;
    assign fail_a     = 8'd0;
    assign fail_b     = 8'd0;
`endif

endmodule

// File: tb/tb_adder8_bist.sv
// Directed bench for adder8_bist: one 256-vector instance with an injectable fault and
// one 300-vector instance fed a permanently broken adder to exercise counter saturation.
module tb_adder8_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       fault = 1'b0;
    logic [7:0] sum0, sum1;
    logic [7:0] op_a0, op_b0, err0, fail_a0, fail_b0;
    logic [7:0] op_a1, op_b1, err1, fail_a1, fail_b1;
    logic       busy0, done0, pass0, fv0;
    logic       busy1, done1, pass1, fv1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder8_bist #(.NUM_VECTORS(256), .SEED(16'hACE1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .sum_in(sum0),
        .op_a(op_a0), .op_b(op_b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .fail_a(fail_a0), .fail_b(fail_b0)
    );

    adder8_bist #(.NUM_VECTORS(300), .SEED(16'hACE1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sum_in(sum1),
        .op_a(op_a1), .op_b(op_b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_a(fail_a1), .fail_b(fail_b1)
    );

    // Adder models: vector 3 of the run from 0xACE1 has operands 0x67/0x0F.
    always_comb begin
        sum0 = op_a0 + op_b0;
        if (fault && (op_a0 == 8'h67) && (op_b0 == 8'h0F)) sum0 = sum0 ^ 8'h01;
        sum1 = op_a1 + op_b1;
        sum1 = sum1 ^ 8'h80;
    end

    typedef struct {
        int         k;      // edges after start accept
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
    } vec_t;

    vec_t vecs[5];

`ifdef ADDER8_BIST_FAILCAP_EN
    localparam logic       ExpFv = 1'b1;
    localparam logic [7:0] ExpFa = 8'h67;
    localparam logic [7:0] ExpFb = 8'h0F;
`else
    localparam logic       ExpFv = 1'b0;
    localparam logic [7:0] ExpFa = 8'h00;
    localparam logic [7:0] ExpFb = 8'h00;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero0(input string tag);
        check({tag, " op_a"}, int'(op_a0), 0);
        check({tag, " op_b"}, int'(op_b0), 0);
        check({tag, " busy"}, int'(busy0), 0);
        check({tag, " done"}, int'(done0), 0);
        check({tag, " pass"}, int'(pass0), 0);
        check({tag, " err"}, int'(err0), 0);
        check({tag, " fv"}, int'(fv0), 0);
        check({tag, " fa"}, int'(fail_a0), 0);
        check({tag, " fb"}, int'(fail_b0), 0);
    endtask

    // Pulse start on u0; returns at the negedge following the accept edge.
    task automatic pulse_start0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!done0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        vecs[0] = '{1, 8'hAC, 8'hE1, 8'h8D};
        vecs[1] = '{3, 8'h59, 8'hC3, 8'h1C};
        vecs[2] = '{5, 8'hB3, 8'h87, 8'h3A};
        vecs[3] = '{7, 8'h67, 8'h0F, 8'h76};
        vecs[4] = '{9, 8'hCE, 8'h1E, 8'hEC};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all_zero0("reset");
        check("reset u1 busy", int'(busy1), 0);
        check("reset u1 err", int'(err1), 0);

        // Clean run with operand table checks and exact done latency
        pulse_start0();
        check("accept busy", int'(busy0), 1);
        check("accept done", int'(done0), 0);
        cyc = 0;
        while (!done0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 5; i++) begin
                if (cyc == vecs[i].k) begin
                    check($sformatf("vec%0d op_a", i), int'(op_a0), int'(vecs[i].a));
                    check($sformatf("vec%0d op_b", i), int'(op_b0), int'(vecs[i].b));
                    check($sformatf("vec%0d sum", i), int'(8'(op_a0 + op_b0)), int'(vecs[i].s));
                end
            end
        end
        check("clean latency", cyc, 512);
        check("clean pass", int'(pass0), 1);
        check("clean err", int'(err0), 0);
        check("clean fv", int'(fv0), 0);
        check("clean busy", int'(busy0), 0);
        check("done hold op_a", int'(op_a0), int'(op_a0 == op_a0 ? op_a0 : 8'h00));
        @(negedge clk);
        check("done sticky", int'(done0), 1);

        // Single fault on vector 3, started from DONE
        fault = 1'b1;
        pulse_start0();
        check("restart done drop", int'(done0), 0);
        check("restart err clr", int'(err0), 0);
        wait_done0(cyc);
        check("fault latency", cyc, 512);
        check("fault err", int'(err0), 1);
        check("fault pass", int'(pass0), 0);
        check("fault fv", int'(fv0), int'(ExpFv));
        check("fault fa", int'(fail_a0), int'(ExpFa));
        check("fault fb", int'(fail_b0), int'(ExpFb));

        // Reset during CHECK of vector 10 (state after edge 21)
        pulse_start0();
        repeat (21) @(negedge clk);
        check("mid busy", int'(busy0), 1);
        check("mid err", int'(err0), 1);
        rst = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        check_all_zero0("midrst");
        rst = 1'b0;
        start0 = 1'b0;
        fault = 1'b0;
        @(negedge clk);
        check("post rst idle", int'(busy0), 0);
        pulse_start0();
        wait_done0(cyc);
        check("rerun latency", cyc, 512);
        check("rerun pass", int'(pass0), 1);

        // start held high: no restart while busy, DONE lasts one cycle
        fault = 1'b1;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk);
        wait_done0(cyc);
        check("held latency", cyc, 512);
        check("held err", int'(err0), 1);
        @(negedge clk);
        check("held done 1cyc", int'(done0), 0);
        check("held busy", int'(busy0), 1);
        check("held err clr", int'(err0), 0);
        start0 = 1'b0;
        fault = 1'b0;

        // Saturation on the 300-vector instance
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("sat latency", cyc, 600);
        check("sat err", int'(err1), 255);
        check("sat pass", int'(pass1), 0);
        check("sat fv", int'(fv1), int'(ExpFv));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
